// File: rtl/clb_pkg.sv
// Shared definitions for the parameterised CLB.
//   - clb_state_e : configuration FSM states
//   - OSEL_*      : slice output-mux selects
//   - SRMODE_*    : slice set/reset modes
//   - *_off/*_msb : per-slice config field positions for a given LUT_K
// Optional feature macro: CLB_READBACK_EN (adds the READBACK state).
package clb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_RUN      = 3'd2,
    ST_RELOAD   = 3'd3
`ifdef CLB_READBACK_EN
    , ST_READBACK = 3'd4
`endif
  } clb_state_e;

  localparam logic [1:0] OSEL_LUT  = 2'b00;  // O = own LUT
  localparam logic [1:0] OSEL_FF   = 2'b01;  // O = own flop
  localparam logic [1:0] OSEL_NBR  = 2'b10;  // O = next slice's LUT
  localparam logic [1:0] OSEL_ZERO = 2'b11;

  localparam logic [1:0] SRMODE_NONE = 2'b00;
  localparam logic [1:0] SRMODE_SET  = 2'b01;
  localparam logic [1:0] SRMODE_RST  = 2'b10;
  localparam logic [1:0] SRMODE_IGN  = 2'b11;

  // Slice layout: {CE_EN, INIT, SRMODE[1:0], OSEL[1:0], LUT[2^K-1:0]}
  function automatic int lut_msb(input int k);    return (1 << k) - 1; endfunction
  function automatic int osel_off(input int k);   return (1 << k);     endfunction
  function automatic int srmode_off(input int k); return (1 << k) + 2; endfunction
  function automatic int init_off(input int k);   return (1 << k) + 4; endfunction
  function automatic int ce_en_off(input int k);  return (1 << k) + 5; endfunction
  function automatic int slice_bits(input int k); return (1 << k) + 6; endfunction

endpackage

// File: rtl/clb_slice.sv
// One CLB slice: 2^LUT_K LUT, storage flop, output mux.
// Ports:
//   gclk, grst_n : clock, async active-low reset
//   cfg          : this slice's active configuration word
//   init_new     : INIT bit of the configuration being committed
//   commit       : commit cycle; flop loads init_new regardless of SR/CE
//   run          : active configuration valid (cfg_done)
//   i, sr, ce    : LUT inputs, set/reset request, clock enable
//   l_nbr        : LUT output of the next slice (for OSEL=10)
//   l, o, q      : LUT output, slice output, flop output
module clb_slice
  import clb_pkg::*;
#(
  parameter int LUT_K = 4
) (
  input  logic                          gclk,
  input  logic                          grst_n,
  input  logic [slice_bits(LUT_K)-1:0]  cfg,
  input  logic                          init_new,
  input  logic                          commit,
  input  logic                          run,
  input  logic [LUT_K-1:0]              i,
  input  logic                          sr,
  input  logic                          ce,
  input  logic                          l_nbr,
  output logic                          l,
  output logic                          o,
  output logic                          q
);

  logic [lut_msb(LUT_K):0] lut;
  logic [1:0]              osel, srmode;
  logic                    ce_en;
  // Active INIT is only meaningful at commit time, where the incoming
  // value from the shadow register is used instead.
  logic                    unused_init;

  assign lut         = cfg[lut_msb(LUT_K):0];
  assign osel        = cfg[osel_off(LUT_K) +: 2];
  assign srmode      = cfg[srmode_off(LUT_K) +: 2];
  assign ce_en       = cfg[ce_en_off(LUT_K)];
  assign unused_init = cfg[init_off(LUT_K)];

  assign l = lut[i];

  always_comb begin
    o = 1'b0;
    if (run) begin
      case (osel)
        OSEL_LUT: o = l;
        OSEL_FF:  o = q;
        OSEL_NBR: o = l_nbr;
        default:  o = 1'b0;
      endcase
    end
  end

  // SR beats CE; modes 00/11 ignore SR.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)                            q <= 1'b0;
    else if (commit)                        q <= init_new;
    else if (run) begin
      if (sr && srmode == SRMODE_SET)       q <= 1'b1;
      else if (sr && srmode == SRMODE_RST)  q <= 1'b0;
      else if (!ce_en || ce)                q <= l;
    end
  end

endmodule

// File: rtl/clb_param.sv
// Parameterised CLB: NUM_SLICE slices with run-time serial configuration
// through a double-buffered shadow/active register. CLBs daisy-chain via
// cfg_din -> cfg_dout.
// Ports:
//   K, RN      : clock, async active-low reset
//   I          : LUT inputs, slice s uses I[s*LUT_K +: LUT_K]
//   SR, CE     : per-slice set/reset request and clock enable
//   cfg_en     : shift enable; cfg_din serial in; cfg_dout = shadow MSB
//   cfg_rb     : (CLB_READBACK_EN only) copy active to shadow for readout
//   cfg_done   : active configuration valid
//   O, Q       : slice outputs, slice flop outputs
// Optional feature macro: CLB_READBACK_EN.
module clb_param
  import clb_pkg::*;
#(
  parameter int LUT_K     = 4,
  parameter int NUM_SLICE = 2
) (
  input  logic                         K,
  input  logic                         RN,
  input  logic [NUM_SLICE*LUT_K-1:0]   I,
  input  logic [NUM_SLICE-1:0]         SR,
  input  logic [NUM_SLICE-1:0]         CE,
  input  logic                         cfg_en,
  input  logic                         cfg_din,
`ifdef CLB_READBACK_EN
  input  logic                         cfg_rb,
`endif
  output logic                         cfg_dout,
  output logic                         cfg_done,
  output logic [NUM_SLICE-1:0]         O,
  output logic [NUM_SLICE-1:0]         Q
);

  localparam int SB    = slice_bits(LUT_K);
  localparam int CFG_W = NUM_SLICE * SB;
  localparam int CW    = $clog2(CFG_W + 1);

  logic [CFG_W-1:0]     shadow, active;
  logic [CW-1:0]        cnt;
  clb_state_e           state, state_nxt;
  logic                 commit;   // high during the single copy cycle
  logic                 last;
  logic                 rb_go;
  logic [NUM_SLICE-1:0] l;

  assign last = cfg_en && (cnt == CW'(CFG_W - 1));

`ifdef CLB_READBACK_EN
  assign rb_go    = cfg_rb && (state == ST_RUN);
  assign cfg_done = (state == ST_RUN) || (state == ST_RELOAD) ||
                    (state == ST_READBACK);
`else
  assign rb_go    = 1'b0;
  assign cfg_done = (state == ST_RUN) || (state == ST_RELOAD);
`endif

  assign cfg_dout = shadow[CFG_W-1];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (cfg_en) state_nxt = ST_LOAD;
      // The state changes on the copy edge so cfg_done rises together
      // with the new active configuration.
      ST_LOAD,
      ST_RELOAD: if (commit) state_nxt = cfg_en ? ST_RELOAD : ST_RUN;
`ifdef CLB_READBACK_EN
      ST_RUN:    if (rb_go) state_nxt = ST_READBACK;
                 else if (cfg_en) state_nxt = ST_RELOAD;
      ST_READBACK: if (last) state_nxt = ST_RUN;
`else
      ST_RUN:    if (cfg_en) state_nxt = ST_RELOAD;
`endif
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge K or negedge RN) begin
    if (!RN) begin
      shadow <= '0;
      active <= '0;
      cnt    <= '0;
      state  <= ST_IDLE;
      commit <= 1'b0;
    end else begin
      state  <= state_nxt;
      commit <= 1'b0;
      if (commit) active <= shadow;
      if (rb_go) begin
        shadow <= active;
        cnt    <= '0;
      end else if (cfg_en) begin
        shadow <= {shadow[CFG_W-2:0], cfg_din};
        // Final shift of a load arms the copy; a readback just ends.
        cnt    <= last ? '0 : cnt + CW'(1);
        commit <= last && (state == ST_LOAD || state == ST_RELOAD);
      end
    end
  end

  for (genvar s = 0; s < NUM_SLICE; s++) begin : g_slice
    clb_slice #(.LUT_K(LUT_K)) u_slice (
      .gclk     (K),
      .grst_n   (RN),
      .cfg      (active[s*SB +: SB]),
      .init_new (shadow[s*SB + init_off(LUT_K)]),
      .commit   (commit),
      .run      (cfg_done),
      .i        (I[s*LUT_K +: LUT_K]),
      .sr       (SR[s]),
      .ce       (CE[s]),
      .l_nbr    (l[(s + 1) % NUM_SLICE]),
      .l        (l[s]),
      .o        (O[s]),
      .q        (Q[s])
    );
  end

endmodule

// File: tb/tb_clb_param.sv
// Self-checking bench for clb_param (LUT_K=4, NUM_SLICE=2, CFG_W=44).
module tb_clb_param;

  localparam int LUT_K = 4;
  localparam int NS    = 2;
  localparam int SB    = 22;
  localparam int CFG_W = NS * SB;

  logic               K = 1'b0;
  logic               RN;
  logic [NS*LUT_K-1:0] I;
  logic [NS-1:0]      SR, CE;
  logic               cfg_en, cfg_din;
`ifdef CLB_READBACK_EN
  logic               cfg_rb;
`endif
  logic               cfg_dout, cfg_done;
  logic [NS-1:0]      O, Q;

  int checks = 0;
  int errors = 0;
  logic [CFG_W-1:0] m_shadow;

  clb_param #(.LUT_K(LUT_K), .NUM_SLICE(NS)) dut (
    .K(K), .RN(RN), .I(I), .SR(SR), .CE(CE),
    .cfg_en(cfg_en), .cfg_din(cfg_din),
`ifdef CLB_READBACK_EN
    .cfg_rb(cfg_rb),
`endif
    .cfg_dout(cfg_dout), .cfg_done(cfg_done), .O(O), .Q(Q)
  );

  always #5 K = ~K;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  function automatic logic [SB-1:0] mk(input logic [15:0] lut, input logic [1:0] osel,
                                       input logic [1:0] srm, input logic init, input logic ce_en);
    return {ce_en, init, srm, osel, lut};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // mode 1: initial load (cfg_done=0, O=0); mode 2: running reload, first CFG_W-1 shifts
  task automatic shift_cfg(input logic [CFG_W-1:0] v, input int lo, input int hi,
                           input int mode, input logic [1:0] exp_o);
    for (int j = lo; j < hi; j++) begin
      cfg_en = 1'b1; cfg_din = v[CFG_W-1-j];
      @(posedge K); #1;
      m_shadow = {m_shadow[CFG_W-2:0], v[CFG_W-1-j]};
      chk("cfg_dout", cfg_dout, m_shadow[CFG_W-1]);
      if (mode == 1) begin
        chk("load_done", cfg_done, 0);
        chk("load_o", O, 0);
      end
      if (mode == 2 && j < CFG_W-1) begin
        chk("run_done", cfg_done, 1);
        chk("run_o", O, exp_o);
      end
    end
    cfg_en = 1'b0;
  endtask

  task automatic step(input logic [7:0] i, input logic [1:0] sr, input logic [1:0] ce,
                      input logic [1:0] eo, input logic [1:0] eq, input string nm);
    I = i; SR = sr; CE = ce;
    @(posedge K); #1;
    chk({nm, "_o"}, O, eo);
    chk({nm, "_q"}, Q, eq);
  endtask

  typedef struct {
    logic [7:0] i;
    logic [1:0] sr, ce, o, q;
  } vec_t;

  vec_t tab[6];
  logic [CFG_W-1:0] cfg_a, cfg_b, cfg_c;

  task automatic run_tab_a();
    for (int n = 0; n < 6; n++)
      step(tab[n].i, tab[n].sr, tab[n].ce, tab[n].o, tab[n].q, $sformatf("tabA%0d", n));
  endtask

  initial begin
    cfg_a = {mk(16'h8000, 2'b01, 2'b00, 1'b0, 1'b0), mk(16'h0116, 2'b00, 2'b00, 1'b0, 1'b0)};
    cfg_b = {mk(16'h8000, 2'b01, 2'b00, 1'b1, 1'b0), mk(16'hFFFF, 2'b00, 2'b00, 1'b1, 1'b0)};
    cfg_c = {mk(16'h0000, 2'b10, 2'b01, 1'b0, 1'b1), mk(16'hFFFF, 2'b01, 2'b10, 1'b1, 1'b1)};
    // slice0 L=1 for nibble 1,2,4,8; slice1 L=1 only for nibble F; O={Q1,L0}
    tab[0] = '{8'hF3, 2'b11, 2'b00, 2'b10, 2'b10};
    tab[1] = '{8'h01, 2'b00, 2'b11, 2'b01, 2'b01};
    tab[2] = '{8'hF8, 2'b10, 2'b01, 2'b11, 2'b11};
    tab[3] = '{8'h74, 2'b01, 2'b10, 2'b01, 2'b01};
    tab[4] = '{8'h00, 2'b11, 2'b11, 2'b00, 2'b00};
    tab[5] = '{8'hFF, 2'b00, 2'b00, 2'b10, 2'b10};

    RN = 1'b0; I = 8'hFF; SR = '0; CE = '0; cfg_en = 1'b0; cfg_din = 1'b0;
`ifdef CLB_READBACK_EN
    cfg_rb = 1'b0;
`endif
    m_shadow = '0;
    #12;
    chk("rst_done", cfg_done, 0);
    chk("rst_dout", cfg_dout, 0);
    chk("rst_o", O, 0);
    chk("rst_q", Q, 0);
    @(negedge K); RN = 1'b1;
    @(posedge K); #1;

    // Load A with a 5-cycle pause after 20 shifts
    shift_cfg(cfg_a, 0, 20, 1, 2'b00);
    for (int c = 0; c < 5; c++) begin
      @(posedge K); #1;
      chk("pause_done", cfg_done, 0);
      chk("pause_o", O, 0);
      chk("pause_dout", cfg_dout, m_shadow[CFG_W-1]);
    end
    shift_cfg(cfg_a, 20, CFG_W, 1, 2'b00);
    @(posedge K); #1;
    chk("commitA_done", cfg_done, 1);
    chk("commitA_q", Q, 0);
    chk("commitA_dout", cfg_dout, cfg_a[CFG_W-1]);
    run_tab_a();

    // Reload B while running; old function holds until the copy
    step(8'h03, 2'b00, 2'b00, 2'b00, 2'b00, "preB");
    shift_cfg(cfg_b, 0, CFG_W, 2, 2'b00);
    @(posedge K); #1;
    chk("commitB_o", O, 2'b11);
    chk("commitB_q", Q, 2'b11);
    chk("commitB_done", cfg_done, 1);
    step(8'h03, 2'b00, 2'b00, 2'b01, 2'b01, "postB");

    // Reload C: slice0 SRMODE=10 OSEL=01, slice1 SRMODE=01 OSEL=10, both CE_EN=1
    shift_cfg(cfg_c, 0, CFG_W, 2, 2'b01);
    @(posedge K); #1;
    chk("commitC_o", O, 2'b11);
    chk("commitC_q", Q, 2'b01);
    step(8'h03, 2'b11, 2'b00, 2'b10, 2'b10, "sr_over");
    step(8'h03, 2'b00, 2'b00, 2'b10, 2'b10, "ce_hold");
    step(8'h03, 2'b00, 2'b11, 2'b11, 2'b01, "ce_load");
    step(8'h03, 2'b11, 2'b11, 2'b10, 2'b10, "sr_prio");
    step(8'h03, 2'b00, 2'b01, 2'b11, 2'b11, "ce_slice");

    // Reset in the middle of a reload
    I = 8'hFF; SR = '0; CE = '0;
    shift_cfg(cfg_a, 0, 30, 0, 2'b00);
    RN = 1'b0; cfg_en = 1'b1;
    #2;
    m_shadow = '0;
    chk("rn_done", cfg_done, 0);
    chk("rn_dout", cfg_dout, 0);
    chk("rn_q", Q, 0);
    chk("rn_o", O, 0);
    @(negedge K); RN = 1'b1; cfg_en = 1'b0;
    shift_cfg(cfg_a, 0, CFG_W, 1, 2'b00);
    @(posedge K); #1;
    chk("rn_reload_done", cfg_done, 1);
    run_tab_a();

`ifdef CLB_READBACK_EN
    I = 8'hF8;
    @(posedge K); #1;
    cfg_rb = 1'b1;
    @(posedge K); #1;
    cfg_rb = 1'b0;
    m_shadow = cfg_a;
    chk("rb_first", cfg_dout, cfg_a[CFG_W-1]);
    shift_cfg('0, 0, CFG_W, 2, 2'b11);
    @(posedge K); #1;
    chk("rb_end_done", cfg_done, 1);
    chk("rb_end_o", O, 2'b11);
    chk("rb_end_q", Q, 2'b11);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
